// File: rtl/ysyx_22041412_ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
package ysyx_22041412_ifu_pkg;

    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ysyx_22041412_ifu_fifo.sv
// Small power-of-2 FIFO with registered storage; head is read straight from the register array.
module ysyx_22041412_ifu_fifo #(
    parameter int                WIDTH   = 96,
    parameter int                DEPTH   = 2,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch: PC, single-outstanding imem request FSM, and a {pc,instr} queue toward decode.
module ysyx_22041412_ifu
    import ysyx_22041412_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = IFU_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc
);
    localparam int CW = $clog2(QDEPTH) + 1;

    ifu_state_e      st;
    logic [63:0]     pc, tag;
    logic            run_en;
    logic            req_hs, q_push, q_pop, q_empty, q_full;
    logic [CW-1:0]   q_count;
    fetch_entry_t    q_din, q_dout;

    // Credit check: only issue when the response is guaranteed a free slot.
    assign imem_req_valid = run_en && (st == ST_RUN) && (q_count < CW'(QDEPTH));
    assign imem_req_addr  = pc;
    assign req_hs         = imem_req_valid & imem_req_ready;

    assign q_pop  = id_valid & id_ready & ~redirect_valid;
    assign q_push = (st == ST_WAIT) & imem_resp_valid & ~redirect_valid & (~q_full | q_pop);
    assign q_din  = '{pc: tag, instr: imem_resp_data};

    assign id_valid = ~q_empty;
    assign id_pc    = q_dout.pc;
    assign id_instr = q_dout.instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= ST_RUN;
            pc     <= RESET_PC;
            tag    <= '0;
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
            if (redirect_valid) begin
                pc <= {redirect_pc[63:2], 2'b00};
                // Any request already accepted must have its response swallowed.
                unique case (st)
                    ST_RUN:           st <= req_hs ? ST_DROP : ST_RUN;
                    ST_WAIT, ST_DROP: st <= imem_resp_valid ? ST_RUN : ST_DROP;
                    default:          st <= ST_RUN;
                endcase
            end else begin
                unique case (st)
                    ST_RUN: if (req_hs) begin
                        pc  <= pc + 64'd4;
                        tag <= pc;
                        st  <= ST_WAIT;
                    end
                    ST_WAIT, ST_DROP: if (imem_resp_valid) st <= ST_RUN;
                    default: st <= ST_RUN;
                endcase
            end
        end
    end

    ysyx_22041412_ifu_fifo #(
        .WIDTH   (96),
        .DEPTH   (QDEPTH),
        .RST_VAL ({64'h0, IFU_NOP})
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redirect_valid),
        .din   (q_din),
        .dout  (q_dout),
        .count (q_count),
        .empty (q_empty),
        .full  (q_full)
    );

endmodule

// File: tb/tb_ysyx_22041412_ifu.sv
// Bench for the fetch unit: memory responder plus a transaction-level expected-stream model.
module tb_ysyx_22041412_ifu;
    localparam int          QD  = 2;
    localparam logic [63:0] RST = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        id_valid, id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [63:0] id_pc;

    ysyx_22041412_ifu #(.RESET_PC(RST), .QDEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; logic [31:0] ins; } ent_t;
    typedef struct { logic [63:0] tgt; logic [63:0] a1; logic [63:0] a2; } rvec_t;

    ent_t        exp_q[$];
    int          ncmp = 0, nfail = 0, n_pop = 0;
    bit          mem_busy = 0, dut_out = 0, wrong = 0, boot = 1, hs_seen = 0;
    int          mem_wait = 0, lat_lo = 1, lat_hi = 1;
    logic [63:0] mem_addr = '0, exp_pc = RST, hs_addr = '0;

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ 32'h8000_0513;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        ncmp++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit rv, input logic [63:0] rpc, input bit rr, input bit idr);
        bit   hs, rsp;
        ent_t e;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        imem_req_ready  = rr && !mem_busy;
        id_ready        = idr;
        imem_resp_valid = mem_busy && (mem_wait == 0);
        imem_resp_data  = imem_resp_valid ? word(mem_addr) : 32'hdead_beef;
        #1;
        chk("id_valid", id_valid, exp_q.size() != 0);
        chk("req_valid", imem_req_valid, !boot && !dut_out && exp_q.size() < QD);
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
        if (id_valid && idr && !rv && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("id_pc", id_pc, e.pc);
            chk("id_instr", id_instr, e.ins);
            n_pop++;
        end
        hs      = imem_req_valid && imem_req_ready;
        rsp     = imem_resp_valid;
        hs_seen = hs;
        hs_addr = imem_req_addr;
        if (rsp) begin
            mem_busy = 0;
            if (dut_out && !wrong && !rv) exp_q.push_back('{mem_addr, word(mem_addr)});
            dut_out = 0;
        end else if (mem_busy && mem_wait > 0) mem_wait--;
        if (hs) begin
            mem_busy = 1;
            mem_addr = imem_req_addr;
            mem_wait = int'($urandom_range(lat_hi, lat_lo)) - 1;
            dut_out  = 1;
            wrong    = 0;
            exp_pc   = exp_pc + 64'd4;
        end
        if (rv) begin
            exp_q.delete();
            exp_pc = {rpc[63:2], 2'b00};
            if (dut_out) wrong = 1;
        end
        boot = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit keep_mem);
        #2;
        rst_n = 0;
        redirect_valid = 0; imem_req_ready = 0; imem_resp_valid = 0; id_ready = 0;
        exp_q.delete();
        exp_pc = RST; dut_out = 0; wrong = 0; boot = 1;
        if (!keep_mem) mem_busy = 0;
        @(negedge clk);
        #1;
        chk("rst_id_valid", id_valid, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_id_instr", id_instr, 32'h0000_0013);
        chk("rst_id_pc", id_pc, 0);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic run_until_hs(input bit rr, input bit idr, output logic [63:0] a);
        bit ok = 0;
        a = '0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step(0, '0, rr, idr);
            if (hs_seen) begin ok = 1; a = hs_addr; end
        end
        chk("hs_timeout", ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rvec_t       vt[4];
        logic [63:0] a, a2, tgt;
        bit          rv;

        vt[0] = '{64'h0000_0000_8000_0103, 64'h0000_0000_8000_0100, 64'h0000_0000_8000_0104};
        vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000};
        vt[2] = '{64'h0000_0000_0000_0002, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0004};
        vt[3] = '{64'h1234_5677_89AB_CDEE, 64'h1234_5677_89AB_CDEC, 64'h1234_5677_89AB_CDF0};

        @(negedge clk);
        do_reset(0);

        // Test 1: first fetch and first delivered word
        lat_lo = 1; lat_hi = 1;
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        chk("t1_hs", hs_seen, 1);
        chk("t1_addr", hs_addr, RST);
        step(0, '0, 1, 0);
        chk("t1_id_valid", id_valid, 1);
        chk("t1_id_pc", id_pc, RST);
        chk("t1_id_instr", id_instr, 32'h0000_0513);

        // Test 2: decode stalled, queue fills to QDEPTH and fetch stops
        for (int i = 0; i < 10; i++) step(0, '0, 1, 0);
        chk("t2_head_pc", id_pc, RST);
        chk("t2_req_valid", imem_req_valid, 0);
        step(0, '0, 1, 1);
        chk("t2_next_pc", id_pc, RST + 64'd4);

        // Test 3: redirect while waiting for a response
        lat_lo = 3; lat_hi = 3;
        run_until_hs(1, 1, a);
        step(1, 64'h0000_0000_8000_0103, 1, 1);
        run_until_hs(1, 1, a);
        chk("t3_addr", a, 64'h0000_0000_8000_0100);

        // Test 4: redirect in the same cycle as the request handshake
        for (int i = 0; i < 60 && !imem_req_valid; i++) step(0, '0, 0, 1);
        step(1, 64'h0000_0000_8000_0200, 1, 1);
        chk("t4_hs", hs_seen, 1);
        run_until_hs(1, 1, a);
        chk("t4_addr", a, 64'h0000_0000_8000_0200);

        // Table: redirect targets with unaligned low bits and 64-bit wrap
        foreach (vt[k]) begin
            lat_lo = 1; lat_hi = 3;
            for (int i = 0; i < 60 && !imem_req_valid; i++) step(0, '0, 0, 1);
            step(1, vt[k].tgt, $urandom_range(1, 0), 1);
            run_until_hs(1, 1, a);
            run_until_hs(1, 1, a2);
            chk("tbl_a1", a, vt[k].a1);
            chk("tbl_a2", a2, vt[k].a2);
        end

        // Test 5: streaming with zero-wait memory, in-order delivery
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
        n_pop = 0;
        for (int i = 0; i < 50; i++) step(0, '0, 1, 1);
        chk("t5_pops_ge20", n_pop >= 20, 1);

        // Test 6: reset while a request is outstanding; late response is ignored
        lat_lo = 2; lat_hi = 2;
        run_until_hs(1, 1, a);
        do_reset(1);
        mem_wait = 1;
        step(0, '0, 1, 1);
        step(0, '0, 1, 1);
        chk("t6_ghost_ignored_qempty", id_valid, 0);
        run_until_hs(1, 1, a);
        chk("t6_addr", a, RST);

        // Randomized traffic against the model
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 500; i++) begin
            rv  = ($urandom % 100) < 6;
            tgt = {$urandom, $urandom};
            if ($urandom % 4 == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
            step(rv, tgt, ($urandom % 100) < 70, ($urandom % 100) < 60);
        end
        for (int i = 0; i < 20; i++) step(0, '0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
